// File: rtl/sram_pkg.sv
// Shared types and constants for the dual-port asynchronous SRAM arbiter.
package sram_pkg;
  localparam int AW_DEF = 19;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/sram_arbiter_if.sv
// Requester bus (CPU port 0, DMA port 1) plus the SRAM pin group.
interface sram_arbiter_if
  import sram_pkg::*;
#(
  parameter int AW = AW_DEF
);
  logic              req0, req1;
  logic              we0, we1;
  logic [AW-1:0]     addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata;
  logic [AW-1:0]     sram_addr;
  logic              sram_ce_n, sram_oe_n, sram_we_n;
  logic              sram_dq_oe;
  logic [DATA_W-1:0] sram_dout;
  logic [DATA_W-1:0] sram_din;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_din,
    output ack0, ack1, rdata, sram_addr, sram_ce_n, sram_oe_n, sram_we_n,
           sram_dq_oe, sram_dout
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_din,
    input  ack0, ack1, rdata, sram_addr, sram_ce_n, sram_oe_n, sram_we_n,
           sram_dq_oe, sram_dout
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a tie goes to the port that did not win last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);
  always_comb begin
    valid = |req;
    grant = 1'b0;
    if (req == 2'b11) begin
      grant = ~last;
    end else begin
      grant = req[1];
    end
  end
endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates CPU/DMA byte accesses onto one asynchronous SRAM with
// registered strobes; a fixed ADDR/ACCESS/DONE sequence per transaction.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int AW          = AW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  sram_arbiter_if.slave bus
);
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t            state;
  logic [1:0]        rst_sync;
  logic              run;
  logic              last, sel, we_q;
  logic              gnt, gnt_vld;
  logic [3:0]        cnt;
  logic              ack0_q, ack1_q;
  logic              ce_n, oe_n, we_n, dq_oe;
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] dout_q, rdata_q;

  rr_arb2 u_rr (
    .req   ({bus.req1, bus.req0}),
    .last  (last),
    .grant (gnt),
    .valid (gnt_vld)
  );

  // Reset asserts immediately but only releases the FSM two edges later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run = rst_sync[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      last    <= 1'b1;
      sel     <= 1'b0;
      we_q    <= 1'b0;
      cnt     <= 4'd0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      ce_n    <= 1'b1;
      oe_n    <= 1'b1;
      we_n    <= 1'b1;
      dq_oe   <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (run && gnt_vld) begin
            state  <= ADDR;
            sel    <= gnt;
            last   <= gnt;
            we_q   <= gnt ? bus.we1 : bus.we0;
            addr_q <= gnt ? bus.addr1 : bus.addr0;
            dout_q <= gnt ? bus.wdata1 : bus.wdata0;
            ce_n   <= 1'b0;
            oe_n   <= 1'b1;
            we_n   <= 1'b1;
            dq_oe  <= gnt ? bus.we1 : bus.we0;
          end
        end
        ADDR: begin
          state <= ACCESS;
          cnt   <= CNT_LOAD;
          if (we_q) begin
            we_n <= 1'b0;
          end else begin
            oe_n <= 1'b0;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state  <= DONE;
            oe_n   <= 1'b1;
            we_n   <= 1'b1;
            ack0_q <= ~sel;
            ack1_q <= sel;
            if (!we_q) begin
              rdata_q <= bus.sram_din;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          // Write data stays driven through DONE for hold time on we_n rise.
          state  <= IDLE;
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          ce_n   <= 1'b1;
          dq_oe  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.rdata      = rdata_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_ce_n  = ce_n;
  assign bus.sram_oe_n  = oe_n;
  assign bus.sram_we_n  = we_n;
  assign bus.sram_dq_oe = dq_oe;
  assign bus.sram_dout  = dout_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: default-wait instance (index 0) and WAIT_CYCLES=1 instance (index 1).
module tb_sram_arbiter;
  localparam int AW = 19;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  logic          rq0[2], rq1[2], w0[2], w1[2];
  logic [AW-1:0] a0[2], a1[2];
  logic [7:0]    d0[2], d1[2];

  logic          ack0_o[2], ack1_o[2], ce_o[2], oe_o[2], wen_o[2], dq_o[2];
  logic [AW-1:0] sa_o[2];
  logic [7:0]    rd_o[2], dout_o[2];
  logic [7:0]    smem0[32], smem1[32];

  sram_arbiter_if #(.AW(AW)) ifa ();
  sram_arbiter_if #(.AW(AW)) ifb ();

  sram_arbiter #(.WAIT_CYCLES(2), .AW(AW)) dut0 (.clk(clk), .reset_n(reset_n), .bus(ifa));
  sram_arbiter #(.WAIT_CYCLES(1), .AW(AW)) dut1 (.clk(clk), .reset_n(reset_n), .bus(ifb));

  always #5 clk = ~clk;

  assign ifa.req0 = rq0[0];  assign ifa.req1 = rq1[0];
  assign ifa.we0 = w0[0];    assign ifa.we1 = w1[0];
  assign ifa.addr0 = a0[0];  assign ifa.addr1 = a1[0];
  assign ifa.wdata0 = d0[0]; assign ifa.wdata1 = d1[0];
  assign ifb.req0 = rq0[1];  assign ifb.req1 = rq1[1];
  assign ifb.we0 = w0[1];    assign ifb.we1 = w1[1];
  assign ifb.addr0 = a0[1];  assign ifb.addr1 = a1[1];
  assign ifb.wdata0 = d0[1]; assign ifb.wdata1 = d1[1];

  assign ack0_o[0] = ifa.ack0;       assign ack0_o[1] = ifb.ack0;
  assign ack1_o[0] = ifa.ack1;       assign ack1_o[1] = ifb.ack1;
  assign ce_o[0] = ifa.sram_ce_n;    assign ce_o[1] = ifb.sram_ce_n;
  assign oe_o[0] = ifa.sram_oe_n;    assign oe_o[1] = ifb.sram_oe_n;
  assign wen_o[0] = ifa.sram_we_n;   assign wen_o[1] = ifb.sram_we_n;
  assign dq_o[0] = ifa.sram_dq_oe;   assign dq_o[1] = ifb.sram_dq_oe;
  assign sa_o[0] = ifa.sram_addr;    assign sa_o[1] = ifb.sram_addr;
  assign rd_o[0] = ifa.rdata;        assign rd_o[1] = ifb.rdata;
  assign dout_o[0] = ifa.sram_dout;  assign dout_o[1] = ifb.sram_dout;

  // External SRAM chips, indexed by the low address bits only.
  assign ifa.sram_din = (!ifa.sram_ce_n && !ifa.sram_oe_n) ? smem0[ifa.sram_addr[4:0]] : 8'h00;
  assign ifb.sram_din = (!ifb.sram_ce_n && !ifb.sram_oe_n) ? smem1[ifb.sram_addr[4:0]] : 8'h00;

  always @(posedge clk) begin
    if (!ifa.sram_ce_n && !ifa.sram_we_n && ifa.sram_dq_oe) smem0[ifa.sram_addr[4:0]] <= ifa.sram_dout;
  end
  always @(posedge clk) begin
    if (!ifb.sram_ce_n && !ifb.sram_we_n && ifb.sram_dq_oe) smem1[ifb.sram_addr[4:0]] <= ifb.sram_dout;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: position within a transaction (0 = idle,
  // 1 = address phase, 2..W+1 = access, W+2 = completion).
  int            m_pos[2];
  int            m_sync;
  logic          m_sel[2], m_we[2], m_last[2];
  logic [AW-1:0] m_addr[2];
  logic [7:0]    m_wd[2], m_rd[2];
  logic [7:0]    mmem[2][32];
  logic          p0[2], p1[2];

  function automatic int wc(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic logic pick(input logic r0, input logic r1, input logic lst);
    if (r0 && r1) return !lst;
    return r1;
  endfunction

  function automatic logic in_acc(input int k);
    return (m_pos[k] >= 2) && (m_pos[k] <= wc(k) + 1);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_sync <= 0;
      for (int k = 0; k < 2; k++) begin
        m_pos[k] <= 0; m_sel[k] <= 1'b0; m_we[k] <= 1'b0; m_last[k] <= 1'b1;
        m_addr[k] <= '0; m_wd[k] <= '0; m_rd[k] <= '0;
      end
    end else begin
      if (m_sync < 2) m_sync <= m_sync + 1;
      for (int k = 0; k < 2; k++) begin
        if (m_pos[k] == 0) begin
          if (m_sync >= 2 && (rq0[k] || rq1[k])) begin
            m_pos[k]  <= 1;
            m_sel[k]  <= pick(rq0[k], rq1[k], m_last[k]);
            m_last[k] <= pick(rq0[k], rq1[k], m_last[k]);
            m_we[k]   <= pick(rq0[k], rq1[k], m_last[k]) ? w1[k] : w0[k];
            m_addr[k] <= pick(rq0[k], rq1[k], m_last[k]) ? a1[k] : a0[k];
            m_wd[k]   <= pick(rq0[k], rq1[k], m_last[k]) ? d1[k] : d0[k];
          end
        end else if (m_pos[k] == wc(k) + 2) begin
          m_pos[k] <= 0;
        end else begin
          m_pos[k] <= m_pos[k] + 1;
          if (m_pos[k] == wc(k) + 1) begin
            if (m_we[k]) mmem[k][m_addr[k][4:0]] <= m_wd[k];
            else         m_rd[k] <= mmem[k][m_addr[k][4:0]];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ce_n[%0d]", k), 32'(ce_o[k]), 32'(m_pos[k] == 0));
      chk($sformatf("oe_n[%0d]", k), 32'(oe_o[k]), 32'(!(in_acc(k) && !m_we[k])));
      chk($sformatf("we_n[%0d]", k), 32'(wen_o[k]), 32'(!(in_acc(k) && m_we[k])));
      chk($sformatf("dq_oe[%0d]", k), 32'(dq_o[k]), 32'((m_pos[k] != 0) && m_we[k]));
      chk($sformatf("ack0[%0d]", k), 32'(ack0_o[k]), 32'((m_pos[k] == wc(k) + 2) && !m_sel[k]));
      chk($sformatf("ack1[%0d]", k), 32'(ack1_o[k]), 32'((m_pos[k] == wc(k) + 2) && m_sel[k]));
      chk($sformatf("sram_addr[%0d]", k), 32'(sa_o[k]), 32'(m_addr[k]));
      chk($sformatf("rdata[%0d]", k), 32'(rd_o[k]), 32'(m_rd[k]));
      if (m_pos[k] != 0 && m_we[k]) chk($sformatf("sram_dout[%0d]", k), 32'(dout_o[k]), 32'(m_wd[k]));
      chk($sformatf("oe_we_low[%0d]", k), 32'(!oe_o[k] && !wen_o[k]), 32'd0);
      chk($sformatf("dq_vs_oe[%0d]", k), 32'(dq_o[k] && !oe_o[k]), 32'd0);
      chk($sformatf("ack_onehot[%0d]", k), 32'(ack0_o[k] && ack1_o[k]), 32'd0);
      chk($sformatf("ack_width[%0d]", k), 32'((ack0_o[k] && p0[k]) || (ack1_o[k] && p1[k])), 32'd0);
      p0[k] <= ack0_o[k];
      p1[k] <= ack1_o[k];
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic xact(input int k, input bit port, input bit we, input logic [AW-1:0] a,
                      input logic [7:0] d, input string nm, output int lat, output int wlo,
                      output bit aok);
    bit got;
    got = 1'b0; lat = 0; wlo = 0; aok = 1'b1;
    if (port) begin rq1[k] = 1'b1; w1[k] = we; a1[k] = a; d1[k] = d; end
    else      begin rq0[k] = 1'b1; w0[k] = we; a0[k] = a; d0[k] = d; end
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (!wen_o[k]) wlo++;
      if (!ce_o[k] && sa_o[k] != a) aok = 1'b0;
      if (port ? ack1_o[k] : ack0_o[k]) begin got = 1'b1; lat = i; end
    end
    chk({nm, "_ack_seen"}, 32'(got), 32'd1);
    #2;
    if (port) rq1[k] = 1'b0; else rq0[k] = 1'b0;
    step();
  endtask

  int lat, wlo;
  bit aok;
  int evp[$];
  int evt[$];
  int n0, n1, wcount;

  initial begin
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rq0[k] = 0; rq1[k] = 0; w0[k] = 0; w1[k] = 0;
      a0[k] = '0; a1[k] = '0; d0[k] = '0; d1[k] = '0;
    end
    repeat (3) step();
    for (int k = 0; k < 2; k++) begin
      chk("rst_ack0", 32'(ack0_o[k]), 32'd0);
      chk("rst_ack1", 32'(ack1_o[k]), 32'd0);
      chk("rst_ce_n", 32'(ce_o[k]), 32'd1);
      chk("rst_oe_n", 32'(oe_o[k]), 32'd1);
      chk("rst_we_n", 32'(wen_o[k]), 32'd1);
      chk("rst_dq_oe", 32'(dq_o[k]), 32'd0);
      chk("rst_addr", 32'(sa_o[k]), 32'd0);
      chk("rst_rdata", 32'(rd_o[k]), 32'd0);
    end
    reset_n = 1'b1;
    repeat (4) step();

    // CPU write then read of the same byte
    xact(0, 1'b0, 1'b1, 19'h00123, 8'hA5, "wr123", lat, wlo, aok);
    chk("wr123_latency", 32'(lat), 32'd4);
    chk("wr123_we_low_cycles", 32'(wlo), 32'd2);
    chk("wr123_addr_hold", 32'(aok), 32'd1);
    xact(0, 1'b0, 1'b0, 19'h00123, 8'h00, "rd123", lat, wlo, aok);
    chk("rd123_latency", 32'(lat), 32'd4);
    chk("rd123_rdata", 32'(rd_o[0]), 32'hA5);
    xact(0, 1'b0, 1'b1, 19'h00010, 8'h3C, "wr10", lat, wlo, aok);
    xact(0, 1'b1, 1'b1, 19'h00020, 8'hC3, "wr20", lat, wlo, aok);
    chk("wr20_latency_p1", 32'(lat), 32'd4);

    // Short-wait instance at the top of the address range
    xact(1, 1'b0, 1'b1, 19'h7FFFF, 8'h5A, "wrmax", lat, wlo, aok);
    chk("wrmax_latency", 32'(lat), 32'd3);
    chk("wrmax_we_low_cycles", 32'(wlo), 32'd1);
    xact(1, 1'b0, 1'b0, 19'h7FFFF, 8'h00, "rdmax", lat, wlo, aok);
    chk("rdmax_latency", 32'(lat), 32'd3);
    chk("rdmax_addr_hold", 32'(aok), 32'd1);
    chk("rdmax_rdata", 32'(rd_o[1]), 32'h5A);

    // Both ports held from reset release: grants must alternate
    reset_n = 1'b0;
    rq0[0] = 1; w0[0] = 0; a0[0] = 19'h00010;
    rq1[0] = 1; w1[0] = 0; a1[0] = 19'h00020;
    step();
    reset_n = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (ack0_o[0]) begin evp.push_back(0); evt.push_back(i); chk("tie_rd0", 32'(rd_o[0]), 32'h3C); end
      if (ack1_o[0]) begin evp.push_back(1); evt.push_back(i); chk("tie_rd1", 32'(rd_o[0]), 32'hC3); end
    end
    chk("tie_ack_count_ge4", 32'(evp.size() >= 4), 32'd1);
    for (int j = 0; j < 4 && j < evp.size(); j++) begin
      chk($sformatf("tie_grant_%0d", j), 32'(evp[j]), 32'(j % 2));
      if (j > 0) chk($sformatf("tie_gap_%0d", j), 32'(evt[j] - evt[j-1]), 32'd5);
    end
    #2;
    rq0[0] = 0; rq1[0] = 0;
    repeat (8) step();

    // DMA alone, held high: back-to-back port 1 transactions
    evt.delete();
    n0 = 0; n1 = 0;
    rq1[0] = 1; w1[0] = 0; a1[0] = 19'h00020;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ack0_o[0]) n0++;
      if (ack1_o[0]) begin n1++; evt.push_back(i); end
    end
    #2;
    rq1[0] = 0;
    chk("dma_ack1_count", 32'(n1), 32'd4);
    chk("dma_ack0_count", 32'(n0), 32'd0);
    if (evt.size() > 0) chk("dma_first_ack", 32'(evt[0]), 32'd4);
    for (int j = 1; j < evt.size(); j++) chk($sformatf("dma_gap_%0d", j), 32'(evt[j] - evt[j-1]), 32'd5);
    repeat (3) step();

    // Reset in the second access cycle of a write aborts it
    rq0[0] = 1; w0[0] = 1; a0[0] = 19'h00456; d0[0] = 8'h77;
    wcount = 0;
    for (int i = 0; i < 10 && wcount < 2; i++) begin
      @(negedge clk);
      if (!wen_o[0]) wcount++;
    end
    chk("abort_reached_access2", 32'(wcount), 32'd2);
    #2;
    reset_n = 1'b0;
    rq0[0] = 0;
    #1;
    chk("abort_we_n", 32'(wen_o[0]), 32'd1);
    chk("abort_dq_oe", 32'(dq_o[0]), 32'd0);
    chk("abort_ce_n", 32'(ce_o[0]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_ack", 32'(ack0_o[0] || ack1_o[0]), 32'd0);
    end
    #2;
    reset_n = 1'b1;
    repeat (4) step();
    xact(0, 1'b0, 1'b0, 19'h00123, 8'h00, "post_abort_rd", lat, wlo, aok);
    chk("post_abort_latency", 32'(lat), 32'd4);
    chk("post_abort_rdata", 32'(rd_o[0]), 32'hA5);

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule
